// File: rtl/alu_v2_pkg.sv
// Shared types and constants for the alu_v2 execute unit.
// Build option ALU_V2_DIV_EN enables the iterative divide ops (12/13).
package alu_v2_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MULU = 4'd10,
        ALU_MULS = 4'd11,
        ALU_DIVU = 4'd12,
        ALU_DIVS = 4'd13,
        ALU_TEST = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    localparam logic [7:0] ERR_NONE  = 8'h00;
    localparam logic [7:0] ERR_DIV0  = 8'h01;
    localparam logic [7:0] ERR_UNDEF = 8'hff;
    localparam logic [7:0] TEST_BYTE = 8'hF7;

endpackage

// File: rtl/alu_v2_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle.
// The divide path exists only when ALU_V2_DIV_EN is defined.
module alu_v2_muldiv
    import alu_v2_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_c,
    output logic [WIDTH-1:0] lo_c,
    output logic [WIDTH-1:0] hi_c
);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opd_q;
    logic             neg_hi_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_n;
    logic [WIDTH-1:0] lo_n;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] prod;

`ifdef ALU_V2_DIV_EN
    logic             div_q;
    logic             neg_lo_q;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   trial;
`else
    logic             unused_is_div;
    assign unused_is_div = is_div;
`endif

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_mag = a_neg ? WIDTH'(-a) : a;
    assign b_mag = b_neg ? WIDTH'(-b) : b;
    assign done_c = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

    // One iteration step on the working registers
    always_comb begin
        rem_n = rem_q;
        lo_n  = lo_q;
        sum   = '0;
`ifdef ALU_V2_DIV_EN
        r_sh  = '0;
        trial = '0;
        if (div_q) begin
            r_sh  = {rem_q[WIDTH-1:0], lo_q[WIDTH-1]};
            trial = r_sh - {1'b0, opd_q};
            if (!trial[WIDTH]) begin
                rem_n = trial;
                lo_n  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_n = r_sh;
                lo_n  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else
`endif
        begin
            sum   = rem_q + (lo_q[0] ? {1'b0, opd_q} : '0);
            rem_n = {1'b0, sum[WIDTH:1]};
            lo_n  = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Final sign correction applied to the last step's value
    always_comb begin
        prod = {rem_n[WIDTH-1:0], lo_n};
        if (neg_hi_q) begin
            prod = -prod;
        end
        lo_c = prod[WIDTH-1:0];
        hi_c = prod[2*WIDTH-1:WIDTH];
`ifdef ALU_V2_DIV_EN
        if (div_q) begin
            lo_c = neg_lo_q ? WIDTH'(-lo_n) : lo_n;
            hi_c = neg_hi_q ? WIDTH'(-rem_n[WIDTH-1:0]) : rem_n[WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (busy_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (done_c) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Divide-by-zero keeps quotient all-ones by never negating it
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            lo_q     <= '0;
            opd_q    <= '0;
            neg_hi_q <= 1'b0;
`ifdef ALU_V2_DIV_EN
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
`endif
        end else if (start) begin
            rem_q    <= '0;
            lo_q     <= a_mag;
            opd_q    <= b_mag;
`ifdef ALU_V2_DIV_EN
            div_q    <= is_div;
            neg_lo_q <= (a_neg ^ b_neg) && (b != '0);
            neg_hi_q <= is_div ? a_neg : (a_neg ^ b_neg);
`else
            neg_hi_q <= a_neg ^ b_neg;
`endif
        end else if (busy_q) begin
            rem_q <= rem_n;
            lo_q  <= lo_n;
        end
    end

endmodule

// File: rtl/alu_v2.sv
// Registered integer ALU with iterative mul/div and valid/ready handshake.
// Define ALU_V2_DIV_EN to implement divu/divs; otherwise they are undefined ops.
module alu_v2
    import alu_v2_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             zero_flag,
    output logic             sign_flag,
    output logic [7:0]       alu_error_vector
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned SH_W  = $clog2(WIDTH);

    alu_state_t       state_q;
    alu_state_t       state_d;
    logic             accept_c;
    logic             is_md_c;
    logic             is_div_c;
    logic             start_c;
    logic             load_sc_c;
    logic             load_md_c;
    logic             md_done_c;
    logic [WIDTH-1:0] md_lo_c;
    logic [WIDTH-1:0] md_hi_c;
    logic [WIDTH-1:0] sc_res_c;
    logic [7:0]       sc_err_c;
    logic [SH_W-1:0]  shamt_c;
    logic             div0_q;

    // A flush on the accept edge drops the operation
    assign accept_c = in_valid && in_ready && !flush;
    assign is_div_c = (op_code == ALU_DIVU) || (op_code == ALU_DIVS);

    // Single-cycle datapath and op classification
    always_comb begin
        sc_res_c = '0;
        sc_err_c = ERR_NONE;
        is_md_c  = 1'b0;
        shamt_c  = b[SH_W-1:0];
        case (alu_op_t'(op_code))
            ALU_ADD:  sc_res_c = a + b;
            ALU_SUB:  sc_res_c = a - b;
            ALU_AND:  sc_res_c = a & b;
            ALU_OR:   sc_res_c = a | b;
            ALU_XOR:  sc_res_c = a ^ b;
            ALU_SLL:  sc_res_c = a << shamt_c;
            ALU_SRL:  sc_res_c = a >> shamt_c;
            ALU_SRA:  sc_res_c = WIDTH'($signed(a) >>> shamt_c);
            ALU_SLT:  sc_res_c = WIDTH'($signed(a) < $signed(b));
            ALU_SLTU: sc_res_c = WIDTH'(a < b);
            ALU_MULU, ALU_MULS: is_md_c = 1'b1;
`ifdef ALU_V2_DIV_EN
            ALU_DIVU, ALU_DIVS: is_md_c = 1'b1;
`endif
            ALU_TEST: sc_res_c = {(WIDTH / 8){TEST_BYTE}};
            default:  sc_err_c = ERR_UNDEF;
        endcase
    end

    alu_v2_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .abort     (flush),
        .start     (start_c),
        .is_div    (is_div_c),
        .is_signed (op_code[0]),
        .a         (a),
        .b         (b),
        .done_c    (md_done_c),
        .lo_c      (md_lo_c),
        .hi_c      (md_hi_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = is_md_c ? BUSY : DONE;
            BUSY:    if (md_done_c) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        start_c   = 1'b0;
        load_sc_c = 1'b0;
        load_md_c = 1'b0;
        case (state_q)
            IDLE: begin
                start_c   = accept_c && is_md_c;
                load_sc_c = accept_c && !is_md_c;
            end
            BUSY:    load_md_c = md_done_c && !flush;
            default: ;
        endcase
    end

    // Handshake and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready         <= 1'b1;
            out_valid        <= 1'b0;
            out              <= '0;
            out_hi           <= '0;
            zero_flag        <= 1'b0;
            sign_flag        <= 1'b0;
            alu_error_vector <= ERR_NONE;
            div0_q           <= 1'b0;
        end else begin
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            if (start_c) begin
                div0_q <= is_div_c && (b == '0);
            end
            if (load_sc_c) begin
                out              <= sc_res_c;
                out_hi           <= '0;
                zero_flag        <= (sc_res_c == '0);
                sign_flag        <= sc_res_c[WIDTH-1];
                alu_error_vector <= sc_err_c;
            end else if (load_md_c) begin
                out              <= md_lo_c;
                out_hi           <= md_hi_c;
                zero_flag        <= (md_lo_c == '0);
                sign_flag        <= md_lo_c[WIDTH-1];
                alu_error_vector <= div0_q ? ERR_DIV0 : ERR_NONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_v2.sv
// Scoreboard bench for alu_v2: directed ops, latency, hold, flush and reset.
module tb_alu_v2;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op_code = 4'd0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic [W-1:0] out_hi;
    logic         zero_flag;
    logic         sign_flag;
    logic [7:0]   alu_error_vector;

    typedef struct {
        string        name;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [7:0]   err;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   prev_valid = 1'b0;

    alu_v2 #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .a                (a),
        .b                (b),
        .op_code          (op_code),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out              (out),
        .out_hi           (out_hi),
        .zero_flag        (zero_flag),
        .sign_flag        (sign_flag),
        .alu_error_vector (alu_error_vector)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented result against the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=1 expected=0 out=%h", out);
            end else begin
                e = sb[0];
                if (!prev_valid) chk({e.name, "_latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
                chk({e.name, "_out"}, 64'(out), 64'(e.lo));
                chk({e.name, "_out_hi"}, 64'(out_hi), 64'(e.hi));
                chk({e.name, "_zero"}, 64'(zero_flag), 64'(e.lo == '0));
                chk({e.name, "_sign"}, 64'(sign_flag), 64'(e.lo[W-1]));
                chk({e.name, "_err"}, 64'(alu_error_vector), 64'(e.err));
                chk({e.name, "_in_ready_low"}, 64'(in_ready), 64'(0));
                if (out_ready) sb.delete(0);
            end
        end
        prev_valid = (out_valid === 1'b1);
    end

    task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                         input logic [7:0] eerr, input int elat, input bit push);
        int   n;
        int   base;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_in_ready_timeout actual=%b expected=1", name, in_ready);
            return;
        end
        op_code  = op;
        a        = ia;
        b        = ib;
        in_valid = 1'b1;
        base     = cyc;
        @(posedge clk);
        if (push) begin
            e.name = name;
            e.lo   = elo;
            e.hi   = ehi;
            e.err  = eerr;
            e.lat  = elat;
            e.acc  = base + 1;
            sb.push_back(e);
        end
        #1;
        in_valid = 1'b0;
        a        = ~ia;
        b        = ~ib;
        op_code  = 4'd0;
    endtask

    task automatic quiet_window(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        chk({name, "_no_out_valid"}, 64'(seen), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        bit div_en;
`ifdef ALU_V2_DIV_EN
        div_en = 1'b1;
`else
        div_en = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out", 64'(out), 64'(0));
        chk("rst_out_hi", 64'(out_hi), 64'(0));
        chk("rst_flags", 64'({zero_flag, sign_flag}), 64'(0));
        chk("rst_err", 64'(alu_error_vector), 64'(0));
        rst = 1'b0;

        issue("add_7_m7", 4'd0, 32'd7, 32'hFFFF_FFF9, 32'd0, 32'd0, 8'h00, 1, 1'b1);
        @(negedge clk);
        chk("add_in_ready_done", 64'(in_ready), 64'(0));
        @(negedge clk);
        chk("add_in_ready_back", 64'(in_ready), 64'(1));

        issue("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 32'd0, 8'h00, 1, 1'b1);
        issue("and", 4'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 32'd0, 8'h00, 1, 1'b1);
        issue("or",  4'd3, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 32'd0, 8'h00, 1, 1'b1);
        issue("xor", 4'd4, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 32'd0, 8'h00, 1, 1'b1);
        issue("sll", 4'd5, 32'd1, 32'h0000_003F, 32'h8000_0000, 32'd0, 8'h00, 1, 1'b1);
        issue("srl", 4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000, 32'd0, 8'h00, 1, 1'b1);
        issue("sra", 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 32'd0, 8'h00, 1, 1'b1);
        issue("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 8'h00, 1, 1'b1);
        issue("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 8'h00, 1, 1'b1);

        issue("mulu_max", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 8'h00, 33, 1'b1);
        issue("muls_m3_5", 4'd11, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 8'h00, 33, 1'b1);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        chk("muls_busy_in_ready_low", 64'(bad), 64'(0));

        if (div_en) begin
            issue("divu_by0", 4'd12, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 8'h01, 33, 1'b1);
            issue("divs_ovf", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 8'h00, 33, 1'b1);
            issue("divu_100_7", 4'd12, 32'd100, 32'd7, 32'd14, 32'd2, 8'h00, 33, 1'b1);
        end else begin
            issue("divu_undef", 4'd12, 32'd100, 32'd0, 32'd0, 32'd0, 8'hFF, 1, 1'b1);
            issue("divs_undef", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 8'hFF, 1, 1'b1);
        end

        // Result held with out_ready low, then released
        @(posedge clk);
        #1 out_ready = 1'b0;
        if (div_en)
            issue("divs_hold", 4'd13, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 8'h00, 33, 1'b1);
        else
            issue("divs_hold", 4'd13, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 8'hFF, 1, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("hold_out_valid_seen", 64'(out_valid), 64'(1));
        repeat (5) @(negedge clk);
        chk("hold_still_valid", 64'(out_valid), 64'(1));
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("hold_release_in_ready", 64'(in_ready), 64'(1));

        issue("undef14", 4'd14, 32'd3, 32'd4, 32'd0, 32'd0, 8'hFF, 1, 1'b1);
        issue("test15", 4'd15, 32'd3, 32'd4, 32'hF7F7_F7F7, 32'd0, 8'h00, 1, 1'b1);

        // Flush in the middle of a multiply
        issue("mulu_flushed", 4'd10, 32'd3, 32'd3, 32'd9, 32'd0, 8'h00, 33, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        quiet_window("flush_busy", 40);
        issue("add_after_flush", 4'd0, 32'd1, 32'd1, 32'd2, 32'd0, 8'h00, 1, 1'b1);

        // Flush on the accept edge drops the op
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        op_code  = 4'd0;
        a        = 32'd5;
        b        = 32'd5;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_accept_in_ready", 64'(in_ready), 64'(1));
        quiet_window("flush_accept", 5);

        // Reset in the middle of a multiply
        issue("test15_pre_rst", 4'd15, 32'd0, 32'd0, 32'hF7F7_F7F7, 32'd0, 8'h00, 1, 1'b1);
        issue("mulu_reset", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 8'h00, 33, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_out", 64'(out), 64'(0));
        chk("midrst_out_hi", 64'(out_hi), 64'(0));
        chk("midrst_flags", 64'({zero_flag, sign_flag}), 64'(0));
        chk("midrst_err", 64'(alu_error_vector), 64'(0));
        quiet_window("midrst", 40);
        issue("add_after_rst", 4'd0, 32'd1, 32'd1, 32'd2, 32'd0, 8'h00, 1, 1'b1);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
